// File: rtl/floppy_head.sv
// Drive head: stepper phases -> track, motor request -> active with spindown, byte pointer over the track buffer.
// Read capture lands on rd_data 1 cycle after terminal count; ram_we is the terminal-count cycle itself; busy/~ready freeze rotation.
module floppy_head #(
  parameter int TRACK_BYTES     = 6656,
  parameter int BYTE_CYCLES     = 458,
  parameter int SPINDOWN_CYCLES = 14318180,
  parameter int MAX_HALFTRACK   = 69
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  phase,
  input  logic        motor_on,
  input  logic        ready,
  input  logic        busy,
  input  logic        wr_mode,
  input  logic [7:0]  wr_data,
  input  logic        wr_strobe,
  input  logic        rd_strobe,
  output logic [7:0]  rd_data,
  output logic [5:0]  track,
  output logic        active,
  output logic [12:0] ram_addr,
  input  logic [7:0]  ram_do,
  output logic [7:0]  ram_di,
  output logic        ram_we
);
  localparam int            CW        = $clog2(BYTE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BYTE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [12:0]   ADDR_LAST = 13'(TRACK_BYTES - 1);
  localparam logic [23:0]   SPIN_LOAD = 24'(SPINDOWN_CYCLES);
  localparam logic [6:0]    HT_MAX    = 7'(MAX_HALFTRACK);

  logic [6:0]    halftrack_q, halftrack_d;
  logic [5:0]    track_q, track_d;
  logic          active_q, active_d;
  logic [23:0]   spin_q, spin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [12:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic [7:0]    latch_q, latch_d;

  logic       rotate, terminal, capture;
  logic [1:0] p, p_up, p_dn;
  logic       step_up, step_dn;

  always_comb begin
    rotate   = active_q & ready & ~busy;
    terminal = rotate & (cnt_q == CNT_LAST);
    capture  = terminal & ~wr_mode;
    ram_we   = terminal & wr_mode;
    p        = halftrack_q[1:0];
    p_up     = p + 2'd1;
    p_dn     = p - 2'd1;
    step_up  = phase[p_up] & ~phase[p_dn];
    step_dn  = phase[p_dn] & ~phase[p_up];
  end

  // Head only moves while the drive is spinning; one half-step per cycle at most.
  always_comb begin
    halftrack_d = halftrack_q;
    if (active_q) begin
      if (step_up && halftrack_q != HT_MAX) halftrack_d = halftrack_q + 7'd1;
      else if (step_dn && halftrack_q != 7'd0) halftrack_d = halftrack_q - 7'd1;
    end
    track_d = halftrack_q[6:1];
  end

  always_comb begin
    active_d = active_q;
    spin_d   = spin_q;
    if (motor_on) begin
      active_d = 1'b1;
      spin_d   = SPIN_LOAD;
    end else if (spin_q != 24'd0) begin
      spin_d = spin_q - 24'd1;
      if (spin_q == 24'd1) active_d = 1'b0;
    end
  end

  // Address is held for the whole byte period so the 1-cycle RAM read is settled at capture.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (rotate) begin
      if (terminal) begin
        cnt_d  = '0;
        addr_d = (addr_q == ADDR_LAST) ? 13'd0 : addr_q + 13'd1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    data_d  = capture ? ram_do : data_q;
    valid_d = capture | (valid_q & ~rd_strobe);
    latch_d = wr_strobe ? wr_data : latch_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halftrack_q <= '0;
      track_q     <= '0;
      active_q    <= 1'b0;
      spin_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      latch_q     <= '0;
    end else begin
      halftrack_q <= halftrack_d;
      track_q     <= track_d;
      active_q    <= active_d;
      spin_q      <= spin_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      latch_q     <= latch_d;
    end
  end

  assign rd_data  = {data_q[7] & valid_q, data_q[6:0]};
  assign track    = track_q;
  assign active   = active_q;
  assign ram_addr = addr_q;
  assign ram_di   = latch_q;

endmodule

// File: tb/tb_floppy_head.sv
// Bench for floppy_head: directed scenarios plus random stimulus, checked every cycle against a byte-stream model.
module tb_floppy_head;
  localparam int TB_BYTES = 16;
  localparam int BC       = 8;
  localparam int SPIN     = 100;
  localparam int HTMAX    = 69;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  phase;
  logic        motor_on, ready, busy, wr_mode, wr_strobe, rd_strobe;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic [5:0]  track;
  logic        active;
  logic [12:0] ram_addr;
  logic [7:0]  ram_do, ram_di;
  logic        ram_we;

  logic [7:0]  mem [TB_BYTES];
  logic        mem_init_done;

  int tests, fails, we_seen;

  // Reference state: absolute rotation ticks stand in for counter + address.
  int          m_ht, m_track, m_off, m_ticks;
  bit          m_active, m_valid;
  logic [7:0]  m_data, m_latch;
  logic [7:0]  m_mem [TB_BYTES];

  always #5 clk = ~clk;

  floppy_head #(
    .TRACK_BYTES(TB_BYTES), .BYTE_CYCLES(BC), .SPINDOWN_CYCLES(SPIN), .MAX_HALFTRACK(HTMAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .phase(phase), .motor_on(motor_on), .ready(ready),
    .busy(busy), .wr_mode(wr_mode), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe), .rd_data(rd_data), .track(track), .active(active),
    .ram_addr(ram_addr), .ram_do(ram_do), .ram_di(ram_di), .ram_we(ram_we)
  );

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < TB_BYTES; i++) mem[i] <= 8'h80 | 8'(i);
    end else if (ram_we) begin
      mem[ram_addr[3:0]] <= ram_di;
    end
    ram_do <= mem[ram_addr[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_rotate();
    return m_active && ready && !busy;
  endfunction

  function automatic bit m_term();
    return m_rotate() && (m_ticks % BC == BC - 1);
  endfunction

  function automatic int m_addr();
    return (m_ticks / BC) % TB_BYTES;
  endfunction

  task automatic model_reset();
    m_ht = 0; m_track = 0; m_off = 0; m_ticks = 0;
    m_active = 0; m_valid = 0; m_data = 8'h00; m_latch = 8'h00;
  endtask

  task automatic compare_all();
    bit exp_we;
    exp_we = m_term() && wr_mode;
    if (ram_we === 1'b1) we_seen++;
    check("track", track, m_track);
    check("active", active, m_active);
    check("ram_addr", ram_addr, m_addr());
    check("ram_we", ram_we, exp_we);
    if (exp_we) check("ram_di", ram_di, m_latch);
    check("rd_data", rd_data, m_valid ? m_data : (m_data & 8'h7f));
  endtask

  task automatic model_edge();
    bit term, up, dn;
    int a, p;
    term = m_term();
    a    = m_addr();
    if (term && wr_mode) m_mem[a] = m_latch;
    if (term && !wr_mode) begin
      m_data  = m_mem[a];
      m_valid = 1;
    end else if (rd_strobe) begin
      m_valid = 0;
    end
    if (m_rotate()) m_ticks++;
    if (wr_strobe) m_latch = wr_data;
    m_track = m_ht / 2;
    if (m_active) begin
      p  = m_ht % 4;
      up = phase[(p + 1) % 4] && !phase[(p + 3) % 4];
      dn = phase[(p + 3) % 4] && !phase[(p + 1) % 4];
      if (up && m_ht < HTMAX) m_ht++;
      else if (dn && m_ht > 0) m_ht--;
    end
    if (motor_on) begin
      m_active = 1; m_off = 0;
    end else if (m_active) begin
      m_off++;
      if (m_off >= SPIN) m_active = 0;
    end
  endtask

  // Called at a falling edge with inputs already driven for the coming rising edge.
  task automatic step();
    #1;
    compare_all();
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_term();
    int n;
    n = 0;
    while (!m_term() && n < 20) begin step(); n++; end
    check("term_reached", m_term(), 1'b1);
  endtask

  task automatic gate_check(input string tag, input bit use_busy);
    int n, base;
    logic [12:0] a0;
    n = 0;
    while (m_ticks % BC != 3 && n < 20) begin step(); n++; end
    a0 = ram_addr;
    base = we_seen;
    if (use_busy) busy = 1'b1; else ready = 1'b0;
    run(20);
    check({tag, "_addr_frozen"}, ram_addr, a0);
    check({tag, "_no_we"}, we_seen - base, 0);
    busy = 1'b0; ready = 1'b1;
    n = 0;
    #1;
    while (ram_we !== 1'b1 && n < 20) begin step(); #1; n++; end
    check({tag, "_resume_cycles"}, n, 4);
  endtask

  int seq_up[4] = '{1, 2, 3, 0};
  int seq_dn[4] = '{3, 2, 1, 0};

  initial begin
    int n, base;
    bit wrap, drop;
    logic [12:0] prev;
    tests = 0; fails = 0; we_seen = 0;
    mem_init_done = 1'b0;
    reset_n = 1'b0; phase = 4'h0; motor_on = 0; ready = 0; busy = 0;
    wr_mode = 0; wr_data = 8'h00; wr_strobe = 0; rd_strobe = 0;
    for (int i = 0; i < TB_BYTES; i++) m_mem[i] = 8'h80 | 8'(i);
    model_reset();
    repeat (3) @(posedge clk);
    mem_init_done = 1'b1;
    @(negedge clk);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_track", track, 6'd0);
    check("rst_active", active, 1'b0);
    check("rst_ram_addr", ram_addr, 13'd0);
    check("rst_ram_we", ram_we, 1'b0);
    reset_n = 1'b1;

    motor_on = 1; ready = 1; busy = 0;
    for (int i = 0; i < 4; i++) begin phase = 4'(1 << seq_up[i]); run(10); end
    check("step_up_track", track, 6'd2);
    for (int i = 0; i < 4; i++) begin phase = 4'(1 << seq_dn[i]); run(10); end
    phase = 4'b1000;
    run(10);
    check("step_down_sat_track", track, 6'd0);
    for (int i = 0; i < 80; i++) begin phase = 4'(1 << ((i + 1) % 4)); run(3); end
    check("step_up_sat_track", track, 6'd34);

    wrap = 0;
    for (int i = 0; i < 2 * BC * TB_BYTES + 4; i++) begin
      prev = ram_addr;
      step();
      if (prev == 13'd15 && ram_addr == 13'd0) wrap = 1;
    end
    check("addr_wrap_seen", wrap, 1'b1);
    wait_term();
    rd_strobe = 1; step(); rd_strobe = 0;
    check("rd_coincident_b7", rd_data[7], 1'b1);
    rd_strobe = 1; step(); rd_strobe = 0;
    check("rd_after_strobe_b7", rd_data[7], 1'b0);

    wr_mode = 1; wr_data = 8'hD5; wr_strobe = 1; step(); wr_strobe = 0;
    base = we_seen;
    run(4 * BC);
    check("we_pulses_32cyc", we_seen - base, 4);
    for (int k = 1; k <= 4; k++)
      check($sformatf("wr_mem_back%0d", k), mem[(int'(ram_addr) - k) & 15], 8'hD5);
    gate_check("busy", 1'b1);
    gate_check("ready", 1'b0);

    motor_on = 0;
    n = 0;
    while (active === 1'b1 && n < 200) begin step(); n++; end
    check($sformatf("spindown_window n=%0d", n), (n >= SPIN - 1 && n <= SPIN + 1), 1'b1);
    motor_on = 1; run(5);
    motor_on = 0; run(50);
    motor_on = 1;
    drop = 0;
    for (int i = 0; i < 150; i++) begin step(); if (active !== 1'b1) drop = 1; end
    check("reassert_no_gap", drop, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) phase = 4'($urandom_range(0, 15));
      if (i % 150 == 0) motor_on = ($urandom_range(0, 2) != 0);
      ready     = ($urandom_range(0, 15) != 0);
      busy      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) wr_mode = ~wr_mode;
      wr_strobe = ($urandom_range(0, 9) == 0);
      wr_data   = 8'($urandom);
      rd_strobe = ($urandom_range(0, 5) == 0);
      step();
    end

    motor_on = 1; ready = 1; busy = 0; wr_mode = 1; wr_strobe = 0; rd_strobe = 0;
    run(2);
    for (int i = 0; i < 8; i++) begin phase = 4'(1 << ((m_ht + 1) % 4)); run(2); end
    check("pre_rst_track_nz", track != 6'd0, 1'b1);
    wait_term();
    #1;
    check("pre_rst_we", ram_we, 1'b1);
    reset_n = 1'b0;
    #1;
    check("arst_ram_we", ram_we, 1'b0);
    check("arst_ram_addr", ram_addr, 13'd0);
    check("arst_active", active, 1'b0);
    check("arst_track", track, 6'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
